// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock timekeeping block.
//   clock_state_e   : set-mode FSM state (RUN, SET_HOUR, SET_MIN)
//   *_W             : field widths for seconds, minutes and hours
//   *_MAX           : inclusive field limits
//   inc_wrap60()    : increment a 6-bit field, wrapping at the given limit
package clock_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2
  } clock_state_e;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX     = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX     = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX_24 = 5'd23;
  localparam logic [HOUR_W-1:0] HOUR_MAX_12 = 5'd12;

  function automatic logic [5:0] inc_wrap60(input logic [5:0] value, input logic [5:0] limit);
    return (value == limit) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a debounced, synchronous button level.
//   Clock : clock
//   Reset : synchronous active-high reset, clears the level history
//   level : button level
//   rise  : high for the cycle in which level is 1 and was 0 on the previous edge
module btn_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Only consumed by registered logic in the parent, so outputs there stay registered.
  assign rise = level & ~level_q;

endmodule

// File: rtl/clock_time_controller.sv
// Timekeeping and time-set sequencer for the digital clock.
// Divides Tick down to 1 Hz, keeps seconds/minutes/hours, runs the button-driven set-mode FSM
// and emits one-cycle carry pulses for the downstream display and alarm chains.
// Build option: define CLOCK_12H_EN for 12-hour mode (Hours 1..12 plus Pm); default is 24-hour.
//   Clock, Reset (sync, active-high), Tick (prescaler enable), ModeBtn, IncBtn (debounced levels)
//   Seconds, Minutes, Hours, Pm          : time fields
//   SecTick, MinTick, HourTick           : one-cycle carry pulses
//   SetMode (0 RUN, 1 SET_HOUR, 2 SET_MIN), Blink (blanking for the edited field)
module clock_time_controller
  import clock_pkg::*;
#(
  parameter int unsigned TicksPerSecond = 1000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Tick,
  input  logic              ModeBtn,
  input  logic              IncBtn,
  output logic [SEC_W-1:0]  Seconds,
  output logic [MIN_W-1:0]  Minutes,
  output logic [HOUR_W-1:0] Hours,
  output logic              Pm,
  output logic              SecTick,
  output logic              MinTick,
  output logic              HourTick,
  output logic [1:0]        SetMode,
  output logic              Blink
);

  localparam int unsigned PW = (TicksPerSecond > 1) ? $clog2(TicksPerSecond) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TicksPerSecond - 1);
  localparam logic [PW-1:0] HalfCnt  = PW'(TicksPerSecond / 2);

`ifdef CLOCK_12H_EN
  localparam logic [HOUR_W-1:0] HourReset = HOUR_MAX_12;
`else
  localparam logic [HOUR_W-1:0] HourReset = 5'd0;
`endif

  clock_state_e      state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d, hour_inc;
  logic              sec_tick_q, sec_tick_d;
  logic              min_tick_q, min_tick_d;
  logic              hour_tick_q, hour_tick_d;
  logic              blink_q, blink_d;
  logic              hour_step, wrap;
  logic              mode_rise, inc_rise;

  btn_edge_detect u_mode_edge (
    .Clock (Clock),
    .Reset (Reset),
    .level (ModeBtn),
    .rise  (mode_rise)
  );

  btn_edge_detect u_inc_edge (
    .Clock (Clock),
    .Reset (Reset),
    .level (IncBtn),
    .rise  (inc_rise)
  );

`ifdef CLOCK_12H_EN
  logic pm_q, pm_d;
  assign hour_inc = (hour_q == HOUR_MAX_12) ? 5'd1 : hour_q + 5'd1;
  // Pm flips whenever the hour advances from 11 to 12, via carry or manual set.
  assign pm_d     = pm_q ^ (hour_step && (hour_q == 5'd11));
  assign Pm       = pm_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pm_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
    end
  end
`else
  assign hour_inc = (hour_q == HOUR_MAX_24) ? 5'd0 : hour_q + 5'd1;
  assign Pm       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_step   = 1'b0;
    sec_tick_d  = 1'b0;
    min_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    wrap        = Tick && (presc_q == PrescMax);

    if (Tick) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
    end

    // A mode edge always takes priority, so a simultaneous increment is dropped.
    unique case (state_q)
      StRun: begin
        if (mode_rise) begin
          state_d = StSetHour;
          sec_d   = '0;
        end else if (wrap) begin
          sec_tick_d = 1'b1;
          sec_d      = inc_wrap60(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX) begin
            min_tick_d = 1'b1;
            min_d      = inc_wrap60(min_q, MIN_MAX);
            if (min_q == MIN_MAX) begin
              hour_tick_d = 1'b1;
              hour_step   = 1'b1;
            end
          end
        end
      end
      StSetHour: begin
        if (mode_rise) begin
          state_d = StSetMin;
        end else if (inc_rise) begin
          hour_step = 1'b1;
        end
      end
      StSetMin: begin
        if (mode_rise) begin
          state_d = StRun;
          presc_d = '0;
        end else if (inc_rise) begin
          min_d = inc_wrap60(min_q, MIN_MAX);
        end
      end
      default: begin
        // Illegal code 3: recover to RUN as a normal RUN entry.
        state_d = StRun;
        presc_d = '0;
      end
    endcase

    hour_d  = hour_step ? hour_inc : hour_q;
    // Computed from next-state values so the registered Blink tracks the prescaler register.
    blink_d = (state_d != StRun) && (presc_d < HalfCnt);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StRun;
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= HourReset;
      sec_tick_q  <= 1'b0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_tick_q  <= sec_tick_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
      blink_q     <= blink_d;
    end
  end

  assign Seconds  = sec_q;
  assign Minutes  = min_q;
  assign Hours    = hour_q;
  assign SecTick  = sec_tick_q;
  assign MinTick  = min_tick_q;
  assign HourTick = hour_tick_q;
  assign SetMode  = state_q;
  assign Blink    = blink_q;

endmodule

// File: doc/clock_time_controller.md
# clock_time_controller

- Timekeeping and time-set sequencer for the digital clock.
- Divides the qualified `Tick` enable down to a 1 Hz rate and maintains the seconds, minutes and hours fields.
- Runs a button-driven set-mode state machine.
- Emits one-cycle carry pulses (`SecTick`, `MinTick`, `HourTick`) that drive the `Tick` inputs of the toggle-flip-flop display and alarm chains downstream.

## Interface
- `TicksPerSecond`, default 1000: number of `Tick`-qualified cycles per second; must be ≥ 2 and even.
- `Clock` input 1: sole clock; all state updates on its rising edge.
- `Reset` input 1: synchronous, active-high; overrides every other input.
- `Tick` input 1: base enable; the prescaler advances only on cycles where it is 1.
- `ModeBtn` input 1: debounced, synchronous level; its rising edge advances the set mode.
- `IncBtn` input 1: debounced, synchronous level; its rising edge increments the selected field.
- `Seconds` output 6: 0..59.
- `Minutes` output 6: 0..59.
- `Hours` output 5: 0..23, or 1..12 with `CLOCK_12H_EN`.
- `Pm` output 1: PM flag; constant 0 without `CLOCK_12H_EN`.
- `SecTick`, `MinTick`, `HourTick` outputs 1 each: one-cycle carry pulses.
- `SetMode` output 2: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.
- `Blink` output 1: display blanking for the field being edited.

## Operation
- State machine states: RUN, SET_HOUR, SET_MIN. Code 3 is illegal and recovers to RUN on the next edge.
- State transitions, each on a rising edge of `ModeBtn`:
  - RUN → SET_HOUR: `Seconds` is cleared to 0 on entry.
  - SET_HOUR → SET_MIN.
  - SET_MIN → RUN.
- Edge detection: button edge = current level 1 and registered previous level 0. A held button produces exactly one action.
- Prescaler:
  - Counts 0..TicksPerSecond-1 on `Tick` cycles and wraps to 0.
  - It runs in every state.
  - On RUN entry it is cleared to 0.
- RUN, prescaler wrap:
  - `Seconds` increments and `SecTick` is 1.
  - If `Seconds` was 59: `Seconds` wraps to 0, `Minutes` increments and `MinTick` is 1.
  - If `Minutes` was also 59: `Minutes` wraps to 0, `Hours` increments and `HourTick` is 1.
  - `Hours` wrap: 23 → 0 in 24 h mode.
- SET_HOUR with an `IncBtn` edge: `Hours` increments with wrap. No carry pulses, no change to `Minutes`.
- SET_MIN with an `IncBtn` edge: `Minutes` increments, wrapping 59 → 0. No carry into `Hours`, no pulses.
- In SET states, seconds do not advance and `SecTick`, `MinTick` and `HourTick` stay 0.
- `Blink`:
  - In SET states: 1 while prescaler < TicksPerSecond/2, else 0.
  - In RUN: 0.
- `ModeBtn` and `IncBtn` edges in the same cycle: the mode change wins and the increment is dropped.
- Arithmetic: field compares are against exact limits (59, 23 or 12). Widths are fixed as listed; no field ever holds an out-of-range value.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- Carry latency: the edge that samples `Tick`=1 with prescaler = TicksPerSecond-1 updates the fields and raises the pulses. The pulses are high for exactly the following cycle, coincident with the new field values.
- Button latency: a button rising in cycle n updates `SetMode` or the field at the edge ending cycle n.
- First second after exiting to RUN: `SecTick` fires TicksPerSecond `Tick` cycles later.
- Reset values: `Seconds`=0, `Minutes`=0, `SetMode`=0, all pulses 0, `Blink`=0, prescaler 0, button history 0.
  - `Hours`=0 and `Pm`=0 without `CLOCK_12H_EN`.
  - `Hours`=12 and `Pm`=0 with `CLOCK_12H_EN`.
- Reset mid-set: the next cycle is RUN with reset values; any pending edge is discarded.

## Configuration
- `CLOCK_12H_EN` defined: 12-hour mode.
  - `Hours` ranges 1..12 and wraps 12 → 1.
  - `Pm` toggles when `Hours` goes 11 → 12, both on a carry and on a SET_HOUR increment.
- `CLOCK_12H_EN` undefined: 24-hour mode.
  - `Hours` ranges 0..23.
  - `Pm` is tied to 0 and its register is not generated.

## Structure
- Package `clock_pkg` holds:
  - the state typedef and encodings (RUN=0, SET_HOUR=1, SET_MIN=2);
  - the field width constants;
  - the limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX_24=23, HOUR_MAX_12=12.
- Sub-module `btn_edge_detect`: registered rising-edge pulse generator, instantiated twice (once per button).
- The prescaler, field counters and FSM live in the top level.

## Test plan
Benches use TicksPerSecond=4.
- Reset, then `Tick` held 1 for 4 cycles → `SecTick` pulses once and `Seconds`=1. After 240 cycles → `Minutes`=1, `Seconds`=0, `MinTick` seen exactly once.
- Preload 23:59:59 via set mode (`Seconds` reaches 59 in RUN), then one wrap → fields 0:00:00 with `SecTick`, `MinTick` and `HourTick` all high in the same cycle. In 12 h mode, 11:59:59 PM=0 → 12:00:00 PM=1.
- `ModeBtn` held high for 10 cycles → `SetMode` goes 0→1 only once. Three separate presses → 1, 2, 0.
- In SET_MIN at `Minutes`=59, one `IncBtn` press → `Minutes`=0, `Hours` unchanged, no pulses. `IncBtn` held → a single increment.
- `ModeBtn` and `IncBtn` rising in the same cycle in SET_HOUR with `Hours`=5 → `SetMode`=2, `Hours` stays 5.
- `Reset` asserted in SET_MIN with `Minutes`=30 and `Blink`=1 → next cycle `SetMode`=0, `Minutes`=0, `Blink`=0, no pulses.
